// File: rtl/aes_ctrl_pkg.sv
// Shared types and helpers for the multi-mode AES sequencer.
package aes_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_CHG_KEY    = 4'd1,
    ST_INIT_READ  = 4'd2,
    ST_INIT_WAIT  = 4'd3,
    ST_WAIT_START = 4'd4,
    ST_READ       = 4'd5,
    ST_WAIT_AES   = 4'd6,
    ST_WRITE      = 4'd7,
    ST_DONE       = 4'd8,
    ST_ERROR      = 4'd9
  } state_e;

  localparam logic AHB_READ  = 1'b0;
  localparam logic AHB_WRITE = 1'b1;

  // An interval of n cycles has elapsed on the cycle where the counter reads n-1.
  function automatic logic interval_elapsed(input logic [31:0] cnt, input logic [31:0] n);
    return cnt == (n - 32'd1);
  endfunction

endpackage

// File: rtl/aes_ctrl_timer.sv
// Saturating interval counter with synchronous clear and count enable.
module aes_ctrl_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/aes_ctrl_multi.sv
// Job sequencer for the AES accelerator: key change or multi-block
// encrypt/decrypt with programmable waits, watchdog, abort and status.
module aes_ctrl_multi
  import aes_ctrl_pkg::*;
#(
  parameter int INIT_WAIT_CYCLES = 10,
  parameter int GAP_CYCLES       = 10,
  parameter int TIMEOUT_CYCLES   = 255,
  parameter int CNT_W            = 8,
  parameter int BLK_W            = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             change_key,
  input  logic             decrypt,
  input  logic [BLK_W-1:0] num_blocks,
  input  logic             last_round,
  input  logic             abort,
  input  logic             chg_key_done,
  input  logic             enc_done,
  output logic             change_key_start,
  output logic             aes_enable,
  output logic             aes_start,
  output logic             aes_decrypt,
  output logic             ahb_mode,
  output logic             ahb_shift_en,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [BLK_W-1:0] blocks_done
);

  localparam logic [BLK_W-1:0] BLK_ONE = {{(BLK_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [BLK_W-1:0] blocks_q, blocks_d;
  logic [BLK_W-1:0] num_q, num_d;
  logic             dec_q, dec_d;
  logic [BLK_W-1:0] blocks_inc;
  logic [CNT_W-1:0] cnt;
  logic             timer_clr;
  logic             init_elapsed;
  logic             gap_elapsed;
  logic             timeout_elapsed;

  aes_ctrl_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr_i(timer_clr),
    .en_i (1'b1),
    .cnt_o(cnt)
  );

  assign blocks_inc      = blocks_q + BLK_ONE;
  assign init_elapsed    = interval_elapsed(32'(cnt), 32'(INIT_WAIT_CYCLES));
  assign gap_elapsed     = interval_elapsed(32'(cnt), 32'(GAP_CYCLES));
  assign timeout_elapsed = interval_elapsed(32'(cnt), 32'(TIMEOUT_CYCLES));

  always_comb begin
    state_d  = state_q;
    blocks_d = blocks_q;
    num_d    = num_q;
    dec_d    = dec_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (change_key) begin
              state_d = ST_CHG_KEY;
            end else if (num_blocks == '0) begin
              state_d = ST_DONE;
            end else begin
              state_d  = ST_INIT_READ;
              num_d    = num_blocks;
              dec_d    = decrypt;
              blocks_d = '0;
            end
          end
        end
        ST_CHG_KEY: begin
          if (chg_key_done) begin
            state_d = ST_DONE;
          end else if (timeout_elapsed) begin
            state_d = ST_ERROR;
          end
        end
        ST_INIT_READ: state_d = ST_INIT_WAIT;
        ST_INIT_WAIT: begin
          if (init_elapsed) begin
            state_d = ST_WAIT_START;
          end
        end
        ST_WAIT_START: begin
          if (gap_elapsed) begin
            state_d = ST_READ;
          end
        end
        ST_READ: state_d = ST_WAIT_AES;
        // A completion arriving on the watchdog's last cycle still counts.
        ST_WAIT_AES: begin
          if (enc_done) begin
            state_d = ST_WRITE;
          end else if (timeout_elapsed) begin
            state_d = ST_ERROR;
          end
        end
        ST_WRITE: begin
          blocks_d = blocks_inc;
          if ((blocks_inc == num_q) || last_round) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT_START;
          end
        end
        ST_DONE:  state_d = ST_IDLE;
        ST_ERROR: state_d = ST_ERROR;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  assign timer_clr = abort || (state_d != state_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      blocks_q <= '0;
      num_q    <= '0;
      dec_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      blocks_q <= blocks_d;
      num_q    <= num_d;
      dec_q    <= dec_d;
    end
  end

  always_comb begin
    change_key_start = 1'b0;
    aes_enable       = 1'b0;
    aes_start        = 1'b0;
    ahb_mode         = AHB_READ;
    ahb_shift_en     = 1'b0;
    busy             = (state_q != ST_IDLE);
    done             = 1'b0;
    error            = 1'b0;
    case (state_q)
      ST_CHG_KEY:    change_key_start = 1'b1;
      ST_INIT_READ:  ahb_shift_en = 1'b1;
      ST_WAIT_START: aes_enable = 1'b1;
      ST_READ: begin
        ahb_shift_en = 1'b1;
        aes_enable   = 1'b1;
        aes_start    = 1'b1;
      end
      ST_WAIT_AES:   aes_enable = 1'b1;
      ST_WRITE: begin
        ahb_mode     = AHB_WRITE;
        ahb_shift_en = 1'b1;
        aes_enable   = 1'b1;
      end
      ST_DONE:       done = 1'b1;
      ST_ERROR:      error = 1'b1;
      default: ;
    endcase
  end

  assign aes_decrypt = dec_q;
  assign blocks_done = blocks_q;

endmodule

// File: doc/aes_ctrl_multi.md
Name: aes_ctrl_multi

Overview:
Parametrised next-generation sequencer for the AES accelerator, sitting between the AHB-lite slave interface, key generator and round engine. It runs one key-change or one multi-block encrypt/decrypt job per start request. Compared with the single-mode controller, it adds programmable wait intervals, a block count, a decrypt mode, a watchdog timeout with an error state, abort, and status outputs.

Parameters:
INIT_WAIT_CYCLES, 10, cycles spent in INIT_WAIT after the first read (1..2^CNT_W-1)
GAP_CYCLES, 10, cycles spent in WAIT_START before each block read (1..2^CNT_W-1)
TIMEOUT_CYCLES, 255, max cycles in CHG_KEY or WAIT_AES before error (1..2^CNT_W-1)
CNT_W, 8, internal interval counter width
BLK_W, 8, width of block count and progress counter

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
start  in  1  job request, sampled only in IDLE
change_key  in  1  at start: 1=key change job, 0=data job
decrypt  in  1  at start: 0=encrypt, 1=decrypt; latched
num_blocks  in  BLK_W  at start: blocks in data job; latched
last_round  in  1  AHB has no more data; ends job after current WRITE
abort  in  1  return to IDLE from any state
chg_key_done  in  1  key generator finished
enc_done  in  1  round engine finished current block
change_key_start  out  1  level to key generator while in CHG_KEY
aes_enable  out  1  round engine enable
aes_start  out  1  one-cycle pulse starting a block
aes_decrypt  out  1  latched mode to round engine
ahb_mode  out  1  0=read from SRAM, 1=write to SRAM
ahb_shift_en  out  1  AHB shift strobe
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on job completion
error  out  1  high while in ERROR
blocks_done  out  BLK_W  blocks written in current job

Behaviour:
- Reset: state=IDLE, counter=0, blocks_done=0, latched num_blocks/decrypt=0, all outputs 0.
- States: IDLE, CHG_KEY, INIT_READ, INIT_WAIT, WAIT_START, READ, WAIT_AES, WRITE, DONE, ERROR.
- Interval counter: cleared on every state change; increments each cycle otherwise; saturates at 2^CNT_W-1. "Interval N elapsed" means cnt==N-1, so the state lasts exactly N cycles.
- IDLE:
  - start&change_key -> CHG_KEY.
  - start&!change_key&num_blocks==0 -> DONE (no AHB activity).
  - start&!change_key otherwise -> INIT_READ; latch num_blocks and decrypt; clear blocks_done.
- CHG_KEY: change_key_start=1; chg_key_done -> DONE; TIMEOUT elapsed -> ERROR.
- INIT_READ (1 cycle): ahb_mode=0, ahb_shift_en=1 -> INIT_WAIT.
- INIT_WAIT: lasts INIT_WAIT_CYCLES -> WAIT_START.
- WAIT_START: aes_enable=1; lasts GAP_CYCLES -> READ.
- READ (1 cycle): ahb_mode=0, ahb_shift_en=1, aes_enable=1, aes_start=1 -> WAIT_AES.
- WAIT_AES: aes_enable=1; enc_done -> WRITE; TIMEOUT elapsed -> ERROR. If both occur in the same cycle, enc_done wins.
- WRITE (1 cycle): ahb_mode=1, ahb_shift_en=1, aes_enable=1; blocks_done increments. If blocks_done+1==latched count or last_round -> DONE, else -> WAIT_START.
- DONE (1 cycle): done=1 -> IDLE. blocks_done holds its value until the next data job starts.
- ERROR: error=1; sticky until abort.
- aes_decrypt equals the latched decrypt bit in all states.
- Priority: abort over everything. abort in any state -> IDLE next cycle; counter cleared, blocks_done kept, no done pulse.
- start outside IDLE is ignored; an IDLE start that coincides with abort is ignored.
- Outputs are Moore, decoded combinationally from state (no extra latency). Every state transition takes effect on the next rising edge.
- Reset asserted mid-job returns the block to reset values immediately (asynchronous).

Decomposition:
- Package aes_ctrl_pkg:
  - 4-bit state enum.
  - Constants AHB_READ=0, AHB_WRITE=1.
  - Helper function for interval-elapsed compare.
- Sub-module aes_ctrl_timer: clear, enable and saturating CNT_W count output. Instantiated once.

Test Plan:
- Key change: start=1, change_key=1; chg_key_done after 5 cycles -> change_key_start high for 5 cycles, done pulse, busy drops, no AHB strobes.
- Data job: num_blocks=3, decrypt=1, enc_done 4 cycles after each aes_start -> shift strobes R,R,W,R,W,R,W; blocks_done=3; aes_decrypt=1 throughout; INIT_WAIT 10 cycles, each WAIT_START 10 cycles; one done pulse.
- Early end: num_blocks=5, last_round=1 during the 2nd WRITE -> DONE after 2 blocks; blocks_done=2.
- Timeout: TIMEOUT_CYCLES=16, enc_done never asserted -> ERROR exactly 16 cycles after entering WAIT_AES; error held 1 until abort, then IDLE with error=0.
- Boundary cases:
  - num_blocks=0 -> DONE one cycle after IDLE, ahb_shift_en never asserted.
  - enc_done coincident with timeout cycle -> WRITE, not ERROR.
- Abort and reset:
  - abort during WAIT_START of block 2 -> IDLE next cycle, blocks_done=1, no done pulse.
  - rst pulse mid-WAIT_AES -> all outputs 0 asynchronously.
